// File: rtl/song_playback_controller.sv
// Song playback controller: primes the 16-slot note window from the score ROM,
// then steps one note per tempo beat with pause/stop and an end-of-song rest flush.
module song_playback_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic [1:0]  song_id,
    input  logic [25:0] tempo_count,
    output logic [8:0]  rom_addr,
    input  logic [3:0]  rom_data,
    output logic        shift_en,
    output logic [3:0]  note_out,
    output logic        beat,
    output logic        playing,
    output logic        done
);

    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned NOTE_W  = 4;
    localparam int unsigned TEMPO_W = 26;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned WINDOW  = 16;

    localparam logic [ADDR_W-1:0] SONG0_BASE = 9'd0;
    localparam logic [ADDR_W-1:0] SONG1_BASE = 9'd128;
    localparam logic [ADDR_W-1:0] SONG2_BASE = 9'd256;
    localparam logic [ADDR_W-1:0] SONG3_BASE = 9'd384;
    localparam logic [NOTE_W-1:0] END_CODE   = 4'hF;

    typedef enum logic [2:0] {
        IDLE, PRIME_ADDR, PRIME_SHIFT, PLAY, PAUSE, FLUSH, DONE
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   rom_addr_nx, base_sel;
    logic [NOTE_W-1:0]   note_nx;
    logic                shift_en_nx, beat_nx, playing_nx, done_nx;
    logic [TEMPO_W-1:0]  tempo_r, tempo_nx, beat_cnt, beat_cnt_nx;
    logic [CNT_W-1:0]    prime_cnt, prime_cnt_nx, flush_cnt, flush_cnt_nx;
    logic                end_seen, end_seen_nx;
    logic                beat_hit, is_end, flush_full;

    always_comb begin
        case (song_id)
            2'd0:    base_sel = SONG0_BASE;
            2'd1:    base_sel = SONG1_BASE;
            2'd2:    base_sel = SONG2_BASE;
            default: base_sel = SONG3_BASE;
        endcase
    end

    assign beat_hit   = (beat_cnt == tempo_r - TEMPO_W'(1));
    assign is_end     = (rom_data == END_CODE);
    assign flush_full = (flush_cnt == CNT_W'(WINDOW));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx     = state;
        rom_addr_nx  = rom_addr;
        note_nx      = '0;
        shift_en_nx  = 1'b0;
        beat_nx      = 1'b0;
        tempo_nx     = tempo_r;
        beat_cnt_nx  = beat_cnt;
        prime_cnt_nx = prime_cnt;
        flush_cnt_nx = flush_cnt;
        end_seen_nx  = end_seen;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx     = PRIME_ADDR;
                    rom_addr_nx  = base_sel;
                    tempo_nx     = (tempo_count < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_count;
                    beat_cnt_nx  = '0;
                    prime_cnt_nx = '0;
                    flush_cnt_nx = '0;
                    end_seen_nx  = 1'b0;
                end
            end
            PRIME_ADDR: state_nx = PRIME_SHIFT;
            PRIME_SHIFT: begin
                shift_en_nx  = 1'b1;
                prime_cnt_nx = prime_cnt + CNT_W'(1);
                if (end_seen || is_end) begin
                    // Rests shifted after the marker count toward the flush total.
                    end_seen_nx  = 1'b1;
                    flush_cnt_nx = flush_cnt + CNT_W'(1);
                end else begin
                    note_nx     = rom_data;
                    rom_addr_nx = rom_addr + ADDR_W'(1);
                end
                if (prime_cnt == CNT_W'(WINDOW - 1)) begin
                    state_nx    = PLAY;
                    beat_cnt_nx = '0;
                end else begin
                    state_nx = PRIME_ADDR;
                end
            end
            PLAY: begin
                if (pause) begin
                    state_nx = PAUSE;
                end else if (end_seen && flush_full) begin
                    state_nx = DONE;
                end else if (beat_hit) begin
                    beat_nx     = 1'b1;
                    shift_en_nx = 1'b1;
                    beat_cnt_nx = '0;
                    if (!end_seen && !is_end) begin
                        note_nx     = rom_data;
                        rom_addr_nx = rom_addr + ADDR_W'(1);
                    end else begin
                        end_seen_nx  = 1'b1;
                        flush_cnt_nx = flush_cnt + CNT_W'(1);
                        state_nx     = FLUSH;
                    end
                end else begin
                    beat_cnt_nx = beat_cnt + TEMPO_W'(1);
                end
            end
            PAUSE: begin
                if (!pause) state_nx = PLAY;
            end
            FLUSH: begin
                // Leave one cycle after the last rest shift so done follows it.
                if (flush_full) begin
                    state_nx = DONE;
                end else if (beat_hit) begin
                    beat_nx      = 1'b1;
                    shift_en_nx  = 1'b1;
                    beat_cnt_nx  = '0;
                    flush_cnt_nx = flush_cnt + CNT_W'(1);
                end else begin
                    beat_cnt_nx = beat_cnt + TEMPO_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (stop) begin
            state_nx     = IDLE;
            rom_addr_nx  = SONG0_BASE;
            note_nx      = '0;
            shift_en_nx  = 1'b0;
            beat_nx      = 1'b0;
            beat_cnt_nx  = '0;
            prime_cnt_nx = '0;
            flush_cnt_nx = '0;
            end_seen_nx  = 1'b0;
        end

        playing_nx = (state_nx == PRIME_ADDR) || (state_nx == PRIME_SHIFT) ||
                     (state_nx == PLAY) || (state_nx == PAUSE) || (state_nx == FLUSH);
        done_nx    = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rom_addr  <= SONG0_BASE;
            note_out  <= '0;
            shift_en  <= 1'b0;
            beat      <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b0;
            tempo_r   <= '0;
            beat_cnt  <= '0;
            prime_cnt <= '0;
            flush_cnt <= '0;
            end_seen  <= 1'b0;
        end else begin
            state     <= state_nx;
            rom_addr  <= rom_addr_nx;
            note_out  <= note_nx;
            shift_en  <= shift_en_nx;
            beat      <= beat_nx;
            playing   <= playing_nx;
            done      <= done_nx;
            tempo_r   <= tempo_nx;
            beat_cnt  <= beat_cnt_nx;
            prime_cnt <= prime_cnt_nx;
            flush_cnt <= flush_cnt_nx;
            end_seen  <= end_seen_nx;
        end
    end

endmodule

// File: tb/tb_song_playback_controller.sv
// Directed bench for song_playback_controller: scenario table plus hand-timed
// sequences for reset, pause, and stop/start collisions.
module tb_song_playback_controller;

    logic        clk = 1'b0;
    logic        reset, start, stop, pause;
    logic [1:0]  song_id;
    logic [25:0] tempo_count;
    logic [8:0]  rom_addr;
    logic [3:0]  rom_data;
    logic        shift_en, beat, playing, done;
    logic [3:0]  note_out;

    logic [3:0] rom [512];
    int checks = 0;
    int errors = 0;

    song_playback_controller dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .song_id(song_id), .tempo_count(tempo_count), .rom_addr(rom_addr),
        .rom_data(rom_data), .shift_en(shift_en), .note_out(note_out),
        .beat(beat), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;

    // Score ROM with one-cycle registered read.
    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic [1:0]  song;
        logic [25:0] tempo;
        int          end_off;
        int          exp_base;
        int          exp_tempo;
        int          exp_total;
        bit          exp_done;
        int          exp_final;
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_rom(input int base, input int end_off);
        for (int i = 0; i < 128; i++)
            rom[base + i] = (i == end_off) ? 4'hF : 4'((i % 14) + 1);
    endtask

    function automatic int exp_note(input int j, input int end_off);
        return (j < end_off) ? (j % 14) + 1 : 0;
    endfunction

    function automatic int shift_time(input int j, input int tempo);
        return (j < 16) ? 3 + 2 * j : 33 + tempo * (j - 15);
    endfunction

    task automatic chk_idle(input string name);
        chk({name, "_addr"}, rom_addr, 0);
        chk({name, "_shift"}, shift_en, 0);
        chk({name, "_note"}, note_out, 0);
        chk({name, "_beat"}, beat, 0);
        chk({name, "_playing"}, playing, 0);
        chk({name, "_done"}, done, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int t, nshift, nbeat, last_t, done_t;
        fill_rom(int'(v.song) * 128, v.end_off);
        song_id = v.song;
        tempo_count = v.tempo;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_addr", rom_addr, v.exp_base);
        nshift = 0; nbeat = 0; last_t = 0; done_t = -1; t = 1;
        while (t < 400 && done_t < 0 && !(!v.exp_done && nshift == v.exp_total)) begin
            if (shift_en) begin
                chk("shift_time", t, shift_time(nshift, v.exp_tempo));
                chk("note", note_out, exp_note(nshift, v.end_off));
                chk("beat_with_shift", beat, int'(nshift >= 16));
                nbeat += int'(beat);
                nshift++;
                last_t = t;
            end
            if (done) done_t = t;
            step();
            t++;
        end
        chk("completed", int'(done_t >= 0 || nshift == v.exp_total), 1);
        chk("shift_count", nshift, v.exp_total);
        chk("beat_count", nbeat, v.exp_total - 16);
        chk("final_addr", rom_addr, v.exp_final);
        if (v.exp_done) begin
            chk("done_latency", done_t, last_t + 1);
            chk("done_level", done, 1);
            chk("playing_in_done", playing, 0);
        end else begin
            chk("still_playing", playing, 1);
            stop = 1'b1;
            step();
            stop = 1'b0;
            chk_idle("stop_play");
        end
    endtask

    initial begin
        // song, tempo, end offset, base, effective tempo, shifts, done, final addr
        vecs[0] = '{2'd1, 26'd5, 1000, 128, 5, 20, 1'b0, 148};
        vecs[1] = '{2'd2, 26'd4,   20, 256, 4, 36, 1'b1, 276};
        vecs[2] = '{2'd3, 26'd0,    3, 384, 2, 19, 1'b1, 387};
        vecs[3] = '{2'd0, 26'd1,   17,   0, 2, 33, 1'b1,  17};

        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        song_id = 2'd0; tempo_count = 26'd0;
        for (int i = 0; i < 512; i++) rom[i] = 4'd0;
        repeat (3) step();
        reset = 1'b0;
        chk_idle("reset");
        step();
        chk_idle("idle_hold");

        // Reset while playing.
        fill_rom(128, 1000);
        song_id = 2'd1; tempo_count = 26'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (35) step();
        chk("mid_play_playing", playing, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("reset_mid_play");

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("stop_in_done");

        // Pause at beat_cnt=2 for 10 cycles, tempo 6.
        fill_rom(128, 1000);
        song_id = 2'd1; tempo_count = 26'd6; start = 1'b1;
        step();
        start = 1'b0;
        repeat (37) step();
        chk("pre_first_beat", beat, 0);
        step();
        chk("first_beat", beat, 1);
        step();
        step();
        pause = 1'b1;
        for (int k = 3; k <= 16; k++) begin
            step();
            if (k == 12) pause = 1'b0;
            chk("pause_quiet", int'(shift_en | beat), 0);
            chk("pause_playing", playing, 1);
        end
        step();
        chk("resume_beat", beat, 1);
        chk("resume_shift", shift_en, 1);
        chk("resume_note", note_out, exp_note(17, 1000));
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_idle("stop_after_pause");

        // Start ignored in PLAY; stop wins over start on a beat cycle.
        fill_rom(256, 1000);
        song_id = 2'd2; tempo_count = 26'd4; start = 1'b1;
        step();
        start = 1'b0;
        repeat (33) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_addr", rom_addr, 272);
        chk("start_ignored_playing", playing, 1);
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk_idle("stop_start");
        step();
        chk("stays_idle", playing, 0);
        chk("stays_idle_addr", rom_addr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
